// File: rtl/elevator_pkg.sv
// Shared constants for the elevator request path: floor width, FSM state encoding and travel direction.
// The insertion comparator on the writer side imports the same definitions.
package elevator_pkg;

  localparam int FLOOR_W = 2;
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = 2'd3;
  localparam logic [FLOOR_W-1:0] BOTTOM_FLOOR = 2'd0;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE      = 2'd1,
    DOOR_OPEN = 2'd2
  } elevator_state_e;

  // One floor in the given direction; holds at the shaft ends instead of wrapping.
  function automatic logic [FLOOR_W-1:0] step_floor(input logic [FLOOR_W-1:0] floor,
                                                   input logic dir);
    logic [FLOOR_W-1:0] nxt;
    nxt = floor;
    if (dir == DIR_UP) begin
      if (floor != TOP_FLOOR) nxt = floor + FLOOR_W'(1);
    end else begin
      if (floor != BOTTOM_FLOOR) nxt = floor - FLOOR_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/elevator_travel_timer.sv
// Down-counter shared by the travel and door phases: load has priority, decrement stops at zero.
module elevator_travel_timer #(
  parameter int TMR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             dec_en,
  output logic             zero
);

  logic [TMR_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec_en && (count_q != '0)) begin
      count_q <= count_q - TMR_W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/elevator_dispatch_fsm.sv
// Reader side of the floor-request memory: serves the head entry, steps the car floor by floor,
// opens the door on arrival and pops the entry. Optional ELEVATOR_ESTOP_EN adds emergency_stop.
module elevator_dispatch_fsm
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16,
  parameter int TMR_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef ELEVATOR_ESTOP_EN
  input  logic               emergency_stop,
`endif
  input  logic               mem_empty,
  input  logic [FLOOR_W-1:0] pos0Mem,
  output logic               pop_Flag,
  output logic [FLOOR_W-1:0] actualFloor,
  output logic               down_up_Flag,
  output logic               motor_up,
  output logic               motor_down,
  output logic               door_open,
  output logic               busy
);

  localparam logic [TMR_W-1:0] TRAVEL_LOAD = TMR_W'(TRAVEL_CYCLES - 1);
  localparam logic [TMR_W-1:0] DOOR_LOAD   = TMR_W'(DOOR_CYCLES - 1);

  elevator_state_e    state_q, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d, next_floor;
  logic               dir_q, dir_d;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]   tmr_load_val;
  logic               estop;

`ifdef ELEVATOR_ESTOP_EN
  assign estop = emergency_stop;
`else
  assign estop = 1'b0;
`endif

  elevator_travel_timer #(.TMR_W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec_en   (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    dir_d        = dir_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    next_floor   = step_floor(floor_q, dir_q);
    case (state_q)
      IDLE: begin
        if (!mem_empty) begin
          if (pos0Mem == floor_q) begin
            state_d      = DOOR_OPEN;
            tmr_load     = 1'b1;
            tmr_load_val = DOOR_LOAD;
          end else if (!estop) begin
            state_d      = MOVE;
            dir_d        = (pos0Mem > floor_q);
            tmr_load     = 1'b1;
            tmr_load_val = TRAVEL_LOAD;
          end
        end
      end
      MOVE: begin
        if (!estop) begin
          if (tmr_zero) begin
            floor_d = next_floor;
            // The head is re-read at every arrival: a nearer request may have replaced it.
            if (!mem_empty && (pos0Mem == next_floor)) begin
              state_d      = DOOR_OPEN;
              tmr_load     = 1'b1;
              tmr_load_val = DOOR_LOAD;
            end else if (!mem_empty) begin
              dir_d        = (pos0Mem > next_floor);
              tmr_load     = 1'b1;
              tmr_load_val = TRAVEL_LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tmr_dec = 1'b1;
          end
        end
      end
      DOOR_OPEN: begin
        if (!estop) begin
          if (tmr_zero) state_d = IDLE;
          else          tmr_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      floor_q      <= BOTTOM_FLOOR;
      dir_q        <= DIR_UP;
      pop_Flag     <= 1'b0;
      motor_up     <= 1'b0;
      motor_down   <= 1'b0;
      door_open    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      dir_q        <= dir_d;
      pop_Flag     <= (state_d == DOOR_OPEN) && (state_q != DOOR_OPEN);
      motor_up     <= (state_d == MOVE) && (dir_d == DIR_UP) && !estop;
      motor_down   <= (state_d == MOVE) && (dir_d == DIR_DOWN) && !estop;
      door_open    <= (state_d == DOOR_OPEN);
      busy         <= (state_d != IDLE);
    end
  end

  assign actualFloor  = floor_q;
  assign down_up_Flag = dir_q;

endmodule

// File: tb/tb_elevator_dispatch_fsm.sv
// Directed bench for elevator_dispatch_fsm with TRAVEL_CYCLES=4, DOOR_CYCLES=4.
module tb_elevator_dispatch_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_empty;
  logic [1:0] pos0Mem;
  logic       pop_Flag, down_up_Flag, motor_up, motor_down, door_open, busy;
  logic [1:0] actualFloor;
`ifdef ELEVATOR_ESTOP_EN
  logic       emergency_stop = 1'b0;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  elevator_dispatch_fsm #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(4), .TMR_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef ELEVATOR_ESTOP_EN
    .emergency_stop (emergency_stop),
`endif
    .mem_empty    (mem_empty),
    .pos0Mem      (pos0Mem),
    .pop_Flag     (pop_Flag),
    .actualFloor  (actualFloor),
    .down_up_Flag (down_up_Flag),
    .motor_up     (motor_up),
    .motor_down   (motor_down),
    .door_open    (door_open),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check(input string tag, input int c, input logic [1:0] e_floor,
                       input logic e_dir, input logic e_up, input logic e_down,
                       input logic e_door, input logic e_pop, input logic e_busy);
    cmp($sformatf("%s c%0d floor", tag, c), {2'b0, actualFloor}, {2'b0, e_floor});
    cmp($sformatf("%s c%0d dir", tag, c), {3'b0, down_up_Flag}, {3'b0, e_dir});
    cmp($sformatf("%s c%0d motor_up", tag, c), {3'b0, motor_up}, {3'b0, e_up});
    cmp($sformatf("%s c%0d motor_down", tag, c), {3'b0, motor_down}, {3'b0, e_down});
    cmp($sformatf("%s c%0d door", tag, c), {3'b0, door_open}, {3'b0, e_door});
    cmp($sformatf("%s c%0d pop", tag, c), {3'b0, pop_Flag}, {3'b0, e_pop});
    cmp($sformatf("%s c%0d busy", tag, c), {3'b0, busy}, {3'b0, e_busy});
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_empty = 1'b1;
    pos0Mem   = 2'd0;
    repeat (3) tick();
    check("reset", 0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check("idle_empty", 0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Floor 0 -> 2: up for 8 cycles, arrivals at cycles 5 and 9, door 9..12.
    pos0Mem = 2'd2; mem_empty = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      tick();
      check("up_0_2", c, (c < 5) ? 2'd0 : (c < 9) ? 2'd1 : 2'd2, 1'b1,
            (c <= 8), 1'b0, (c >= 9 && c <= 12), (c == 9), (c <= 12));
      if (pop_Flag) mem_empty = 1'b1;
    end

    // Request at current floor 2: door the next cycle, idle after 4.
    pos0Mem = 2'd2; mem_empty = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("same_floor", c, 2'd2, 1'b1, 1'b0, 1'b0, (c <= 4), (c == 1), (c <= 4));
      if (pop_Flag) mem_empty = 1'b1;
    end

    // Floor 2 -> 3 to set up the long descent.
    pos0Mem = 2'd3; mem_empty = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      check("up_2_3", c, (c < 5) ? 2'd2 : 2'd3, 1'b1,
            (c <= 4), 1'b0, (c >= 5 && c <= 8), (c == 5), (c <= 8));
      if (pop_Flag) mem_empty = 1'b1;
    end

    // Floor 3 -> 0: down for 12 cycles through floors 2,1,0, door at cycle 13.
    pos0Mem = 2'd0; mem_empty = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      tick();
      check("down_3_0", c, (c < 5) ? 2'd3 : (c < 9) ? 2'd2 : (c < 13) ? 2'd1 : 2'd0, 1'b0,
            1'b0, (c <= 12), (c >= 13 && c <= 16), (c == 13), (c <= 16));
      if (pop_Flag) mem_empty = 1'b1;
    end

    // Floor 0 heading to 3; head replaced by floor 1 before the first arrival.
    pos0Mem = 2'd3; mem_empty = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      check("redirect", c, (c < 5) ? 2'd0 : 2'd1, 1'b1,
            (c <= 4), 1'b0, (c >= 5 && c <= 8), (c == 5), (c <= 8));
      if (c == 2) pos0Mem = 2'd1;
      if (pop_Flag) mem_empty = 1'b1;
    end

    // Floor 1 heading to 3; memory drains mid-move -> idle at the next floor.
    pos0Mem = 2'd3; mem_empty = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check("drained", c, (c < 5) ? 2'd1 : 2'd2, 1'b1, (c <= 4), 1'b0, 1'b0, 1'b0, (c <= 4));
      if (c == 2) mem_empty = 1'b1;
    end

    // Asynchronous reset mid-cycle while moving down from floor 2.
    pos0Mem = 2'd0; mem_empty = 1'b0;
    tick();
    tick();
    check("pre_areset", 2, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("areset", 0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_empty = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_areset", 0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
